// File: rtl/mt_fetch_pkg.sv
// Shared sizing helpers for the barrel-core fetch stage.
package mt_fetch_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned PKT_VALID_W = 1;

   function automatic int unsigned bits_threads(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned pkt_tid_w(input int unsigned n);
      return bits_threads(n);
   endfunction

   function automatic int unsigned pkt_width(input int unsigned data_w,
                                             input int unsigned addr_w,
                                             input int unsigned n);
      return PKT_VALID_W + pkt_tid_w(n) + 2 * addr_w + data_w;
   endfunction

endpackage

// File: rtl/mt_fetch_rr_sel.sv
// Round-robin thread picker: first enabled thread after last_tid, last_tid itself last.
module rr_thread_sel
   import mt_fetch_pkg::*;
#(
   parameter int unsigned NUM_THREADS = 8,
   localparam int unsigned BITS = bits_threads(NUM_THREADS)
) (
   input  logic [NUM_THREADS-1:0] mask,
   input  logic [BITS-1:0]        last_tid,
   output logic [BITS-1:0]        sel,
   output logic                   any
);

   logic [BITS:0] idx;

   // Scan from farthest to nearest so the nearest enabled thread wins.
   always_comb begin
      sel = '0;
      any = 1'b0;
      idx = '0;
      for (int unsigned k = NUM_THREADS; k >= 1; k--) begin
         idx = {1'b0, last_tid} + (BITS+1)'(k);
         if (idx >= (BITS+1)'(NUM_THREADS))
            idx = idx - (BITS+1)'(NUM_THREADS);
         if (mask[idx[BITS-1:0]]) begin
            sel = idx[BITS-1:0];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mt_fetch_rr.sv
// Barrel-core fetch stage: per-thread PC file, round-robin select, registered packet.
module mt_fetch_rr
   import mt_fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned NUM_THREADS   = 8,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = '0,
   parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE = '0,
   localparam int unsigned BITS_THREADS = bits_threads(NUM_THREADS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_THREADS-1:0]   thread_en,
   input  logic                     stall_f,
   input  logic                     pc_src_e,
   input  logic [BITS_THREADS-1:0]  tid_e,
   input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic                     valid_f,
   output logic [BITS_THREADS-1:0]  tid_f,
   output logic [ADDRESS_WIDTH-1:0] pc_f,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
   output logic [DATA_WIDTH-1:0]    instr_f
);

   logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
   logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
   logic [BITS_THREADS-1:0]  last_q, last_d;
   logic                     valid_q, valid_d;
   logic [BITS_THREADS-1:0]  tid_q, tid_d;
   logic [ADDRESS_WIDTH-1:0] pcf_q, pcf_d;
   logic [ADDRESS_WIDTH-1:0] pc4_q, pc4_d;
   logic [DATA_WIDTH-1:0]    instr_q, instr_d;

   logic [BITS_THREADS-1:0]  sel;
   logic                     any;
   logic [ADDRESS_WIDTH-1:0] eff_pc;
   logic [ADDRESS_WIDTH-1:0] eff_pc4;
   logic                     fetch;
   logic                     kill;

   rr_thread_sel #(
      .NUM_THREADS (NUM_THREADS)
   ) u_sel (
      .mask     (thread_en),
      .last_tid (last_q),
      .sel      (sel),
      .any      (any)
   );

   assign eff_pc    = (pc_src_e && (tid_e == sel)) ? pc_target_e : pc_q[sel];
   assign eff_pc4   = eff_pc + ADDRESS_WIDTH'(INSTR_BYTES);
   assign imem_addr = eff_pc;
   assign fetch     = !stall_f && any;
   assign kill      = pc_src_e && valid_q && (tid_e == tid_q);

   // A fetched thread's increment already absorbs a same-cycle redirect via eff_pc.
   always_comb begin
      pc_d = pc_q;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
         if (fetch && (sel == BITS_THREADS'(i)))
            pc_d[i] = eff_pc4;
         else if (pc_src_e && (tid_e == BITS_THREADS'(i)))
            pc_d[i] = pc_target_e;
      end
   end

   always_comb begin
      last_d  = last_q;
      valid_d = valid_q;
      tid_d   = tid_q;
      pcf_d   = pcf_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      if (fetch) begin
         last_d  = sel;
         valid_d = 1'b1;
         tid_d   = sel;
         pcf_d   = eff_pc;
         pc4_d   = eff_pc4;
         instr_d = imem_rdata;
      end else if (!stall_f || kill) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_THREADS; i++)
            pc_q[i] <= RESET_PC + ADDRESS_WIDTH'(i) * THREAD_PC_STRIDE;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q  <= BITS_THREADS'(NUM_THREADS - 1);
         valid_q <= 1'b0;
         tid_q   <= '0;
         pcf_q   <= '0;
         pc4_q   <= '0;
         instr_q <= '0;
      end else begin
         last_q  <= last_d;
         valid_q <= valid_d;
         tid_q   <= tid_d;
         pcf_q   <= pcf_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
      end
   end

   assign valid_f    = valid_q;
   assign tid_f      = tid_q;
   assign pc_f       = pcf_q;
   assign pc_plus4_f = pc4_q;
   assign instr_f    = instr_q;

endmodule

// File: doc/mt_fetch_rr.md
# mt_fetch_rr

Parametrised fetch stage for the barrel RISC-V core. It holds one PC per hardware thread and selects the next thread each cycle round-robin, skipping threads whose enable bit is clear. It takes execute-stage redirects for any thread and drives a registered fetch packet (valid, tid, pc, pc+4, instr) to decode, with stall and kill support. Instruction memory stays outside the block: the block drives the fetch address and receives the instruction word in the same cycle.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDRESS_WIDTH, 32, PC width
- NUM_THREADS, 8, hardware thread count, ≥1
- RESET_PC, 0, reset PC of thread 0
- THREAD_PC_STRIDE, 0, reset PC of thread i is RESET_PC + i·THREAD_PC_STRIDE (modulo 2^ADDRESS_WIDTH)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- thread_en  in  NUM_THREADS  bit i set means thread i is eligible for fetch
- stall_f  in  1  decode cannot accept; hold the packet and do not fetch
- pc_src_e  in  1  redirect valid
- tid_e  in  BITS_THREADS  thread being redirected
- pc_target_e  in  ADDRESS_WIDTH  redirect target
- imem_addr  out  ADDRESS_WIDTH  fetch address, combinational
- imem_rdata  in  DATA_WIDTH  instruction at imem_addr, same cycle
- valid_f, tid_f, pc_f, pc_plus4_f, instr_f  out  1/BITS_THREADS/ADDRESS_WIDTH/ADDRESS_WIDTH/DATA_WIDTH  registered fetch packet

BITS_THREADS = max(1, clog2(NUM_THREADS)).

## Operation
- **State**
  - PC file pc[0..NUM_THREADS-1].
  - last_tid pointer.
  - Output packet registers.
- **Reset**
  - pc[i] = RESET_PC + i·THREAD_PC_STRIDE.
  - last_tid = NUM_THREADS-1.
  - valid_f = 0; tid_f, pc_f, pc_plus4_f, instr_f = 0.
  - imem_addr follows the select logic and is not registered.
- **Select**
  - sel = first i with thread_en[i] = 1, scanning last_tid+1, last_tid+2, … with wrap modulo NUM_THREADS.
  - last_tid itself is checked last.
  - If no bit is set, there is no fetch.
- **Effective PC**
  - eff_pc = pc_target_e when pc_src_e is high and tid_e == sel; otherwise pc[sel].
  - imem_addr = eff_pc.
- **Fetch cycle** (stall_f = 0 and some thread enabled)
  - Packet register loads {1, sel, eff_pc, eff_pc+4, imem_rdata}.
  - pc[sel] ← eff_pc+4.
  - last_tid ← sel.
- **No enabled thread** (stall_f = 0)
  - valid_f ← 0.
  - last_tid and the PCs hold, except for redirects.
- **Stall** (stall_f = 1)
  - Packet, last_tid and non-redirected PCs hold.
  - No PC increment.
- **Redirect to a thread other than the fetched one**
  - pc[tid_e] ← pc_target_e.
  - Applied whether or not stall_f is high, and even if thread_en[tid_e] = 0.
- **Kill**
  - If pc_src_e is high, valid_f = 1 and tid_e == tid_f at an edge where the packet is not being replaced by a new fetch, then valid_f ← 0.
  - This applies during stall as well.
  - A new fetch of thread tid_e already uses the target through eff_pc, so it is not killed.
- **PC arithmetic**
  - PC+4 wraps modulo 2^ADDRESS_WIDTH.
  - pc_target_e is used as given; no alignment check.

## Timing
- Combinational path: thread_en, last_tid and redirect → sel → imem_addr → imem_rdata → packet register.
- Fetch latency: one cycle. A thread selected in cycle t shows valid_f in cycle t+1.
- With all threads enabled and no stall, each thread is fetched exactly once every NUM_THREADS cycles.
- A redirect in cycle t takes effect for that thread's next fetch. If that fetch is in cycle t, it uses the bypass.
- A thread_en change in cycle t affects selection in cycle t.
- Asserting rst mid-stream clears valid_f and the PCs immediately, without waiting for a clock edge.

## Structure
- Package mt_fetch_pkg holds:
  - the function bits_threads(n) = max(1, clog2(n));
  - the packet struct-equivalent field widths.
- Sub-module rr_thread_sel, parametrised on NUM_THREADS:
  - inputs: mask, last_tid;
  - outputs: sel, any.
  - Purely combinational rotate-and-priority-encode.
- The PC file and packet register stay in the top level.

## Test plan
1. **Reset and round-robin.** NUM_THREADS=4, STRIDE=0x100, all threads enabled, no stall → packets in order tid 0,1,2,3,0 with pc 0x000, 0x100, 0x200, 0x300, 0x004; valid_f=0 in the first cycle after reset.
2. **Masked threads.** thread_en=4'b1010 → tid sequence 1,3,1,3; pc of thread 1 advances by 4 per visit; thread_en=0 → valid_f drops to 0 and PCs freeze.
3. **Redirect, non-selected thread.** pc_src_e with tid_e=2, target 0x800, while thread 0 is fetched → thread 2's next packet has pc_f=0x800 and pc_plus4_f=0x804.
4. **Redirect bypass.** Redirect of thread 1 to 0x40 in the same cycle thread 1 is selected → imem_addr=0x40, packet pc_f=0x40, stored pc[1]=0x44.
5. **Stall and kill.** Hold stall_f for 3 cycles → packet and imem sequence frozen; a redirect with tid_e == tid_f during the stall → valid_f falls at the next edge and pc[tid_e]=target; releasing the stall resumes at the next round-robin thread.
6. **Async reset mid-run.** Pulse rst between clock edges → valid_f=0 and PCs back to their reset values before the next edge; the first fetch after reset is tid 0.
